// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the RGB frame buffer.
//   pixel_t    : packed {r, g, b} pixel at the default channel width
//   fb_state_t : read-side FSM states
//   fb_addr    : raster-order linear address, y * width + x
package frame_buffer_pkg;

  localparam int unsigned DefColorBits = 8;

  typedef struct packed {
    logic [DefColorBits-1:0] r;
    logic [DefColorBits-1:0] g;
    logic [DefColorBits-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } fb_state_t;

  function automatic int unsigned fb_addr(input int unsigned x, input int unsigned y,
                                          input int unsigned width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/fb_dp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// The read samples the array before the same-edge write lands, so a same-address
// read/write returns the old word. No reset, so it maps onto block RAM.
//   clk_i            : clock
//   we_i/waddr_i     : write strobe and address
//   wdata_i          : write data
//   re_i/raddr_i     : read enable and address
//   rdata_o          : read data, valid the cycle after re_i
module fb_dp_ram #(
  parameter int unsigned  Depth    = 76800,
  parameter int unsigned  DataBits = 24,
  localparam int unsigned AddrBits = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [DataBits-1:0] wdata_i,
  input  logic                re_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [DataBits-1:0] rdata_o
);

  logic [DataBits-1:0] mem_q [Depth];
  logic [DataBits-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_rgb.sv
// Parametrised RGB frame buffer, one write port and one read port on one clock.
// Reads are random-access (rd_req) or a full raster scan (scan_start); both have
// one cycle of latency. Writes are accepted in every state and never stall.
// Optional build macro FRAME_BUFFER_BYPASS_EN: a same-cycle same-address read
// returns the data being written (write-first); without it the old word returns.
//   clk, rst (sync, active high)
//   wr_en, wr_x, wr_y, wr_rgb         : write port, out-of-range writes dropped
//   rd_req, rd_x, rd_y                : random read, accepted only when idle
//   scan_start                        : raster scan, accepted only when idle, wins over rd_req
//   busy                              : FSM not idle
//   rd_valid, rd_rgb, rd_x_o, rd_y_o  : returned pixel and its coordinates
//   frame_done                        : pulse with the last pixel of a scan
module frame_buffer_rgb
  import frame_buffer_pkg::*;
#(
  parameter int unsigned  WIDTH      = 320,
  parameter int unsigned  HEIGHT     = 240,
  parameter int unsigned  COLOR_BITS = DefColorBits,
  localparam int unsigned X_BITS     = $clog2(WIDTH),
  localparam int unsigned Y_BITS     = $clog2(HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [X_BITS-1:0]       wr_x,
  input  logic [Y_BITS-1:0]       wr_y,
  input  logic [3*COLOR_BITS-1:0] wr_rgb,
  input  logic                    rd_req,
  input  logic [X_BITS-1:0]       rd_x,
  input  logic [Y_BITS-1:0]       rd_y,
  input  logic                    scan_start,
  output logic                    busy,
  output logic                    rd_valid,
  output logic [3*COLOR_BITS-1:0] rd_rgb,
  output logic [X_BITS-1:0]       rd_x_o,
  output logic [Y_BITS-1:0]       rd_y_o,
  output logic                    frame_done
);

  localparam int unsigned PixBits  = 3 * COLOR_BITS;
  localparam int unsigned Depth    = WIDTH * HEIGHT;
  localparam int unsigned AddrBits = $clog2(Depth);
  // One extra bit so a power-of-two dimension still compares correctly.
  localparam logic [X_BITS:0]   XLim  = (X_BITS + 1)'(WIDTH);
  localparam logic [Y_BITS:0]   YLim  = (Y_BITS + 1)'(HEIGHT);
  localparam logic [X_BITS-1:0] XLast = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] YLast = Y_BITS'(HEIGHT - 1);

  fb_state_t         state_q;
  logic [X_BITS-1:0] scan_x_q;
  logic [Y_BITS-1:0] scan_y_q;
  logic              busy_q, rd_valid_q, frame_done_q, rd_hit_q;
  logic [X_BITS-1:0] rd_x_q;
  logic [Y_BITS-1:0] rd_y_q;

  logic                in_idle, in_scan, rd_go, rd_issue, rd_ok, wr_ok;
  logic [X_BITS-1:0]   rd_ax;
  logic [Y_BITS-1:0]   rd_ay;
  logic [AddrBits-1:0] rd_addr, wr_addr;
  logic [PixBits-1:0]  ram_rdata, pix_rdata;

  assign in_idle  = (state_q == StIdle);
  assign in_scan  = (state_q == StScan);
  // A scan request in the same cycle swallows the random read.
  assign rd_go    = in_idle && rd_req && !scan_start;
  assign rd_issue = rd_go || in_scan;
  assign rd_ax    = in_scan ? scan_x_q : rd_x;
  assign rd_ay    = in_scan ? scan_y_q : rd_y;
  assign rd_ok    = ({1'b0, rd_ax} < XLim) && ({1'b0, rd_ay} < YLim);
  assign wr_ok    = wr_en && ({1'b0, wr_x} < XLim) && ({1'b0, wr_y} < YLim);
  assign rd_addr  = AddrBits'(fb_addr(32'(rd_ax), 32'(rd_ay), WIDTH));
  assign wr_addr  = AddrBits'(fb_addr(32'(wr_x), 32'(wr_y), WIDTH));

  fb_dp_ram #(
    .Depth    (Depth),
    .DataBits (PixBits)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_addr),
    .wdata_i (wr_rgb),
    .re_i    (rd_issue && rd_ok),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

`ifdef FRAME_BUFFER_BYPASS_EN
  logic               fwd_q;
  logic [PixBits-1:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= rd_issue && rd_ok && wr_ok && (wr_addr == rd_addr);
      fwd_data_q <= wr_rgb;
    end
  end

  assign pix_rdata = fwd_q ? fwd_data_q : ram_rdata;
`else
  assign pix_rdata = ram_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      rd_hit_q     <= 1'b0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
    end else begin
      rd_valid_q   <= rd_issue;
      frame_done_q <= 1'b0;
      if (rd_issue) begin
        rd_x_q   <= rd_ax;
        rd_y_q   <= rd_ay;
        rd_hit_q <= rd_ok;
      end
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            state_q  <= StScan;
            busy_q   <= 1'b1;
            scan_x_q <= '0;
            scan_y_q <= '0;
          end
        end
        StScan: begin
          if (scan_x_q == XLast) begin
            scan_x_q <= '0;
            if (scan_y_q == YLast) begin
              // Last address issued now; its data and frame_done appear in StDone.
              state_q      <= StDone;
              scan_y_q     <= '0;
              frame_done_q <= 1'b1;
            end else begin
              scan_y_q <= scan_y_q + 1'b1;
            end
          end else begin
            scan_x_q <= scan_x_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign rd_valid   = rd_valid_q;
  assign rd_x_o     = rd_x_q;
  assign rd_y_o     = rd_y_q;
  assign frame_done = frame_done_q;
  // Out-of-range reads and idle cycles present zero.
  assign rd_rgb     = (rd_valid_q && rd_hit_q) ? pix_rdata : '0;

endmodule

// File: tb/tb_frame_buffer_rgb.sv
// Directed bench for frame_buffer_rgb on a reduced 20x12 frame.
module tb_frame_buffer_rgb;
  import frame_buffer_pkg::*;

  localparam int unsigned W  = 20;
  localparam int unsigned H  = 12;
  localparam int unsigned XB = 5;
  localparam int unsigned YB = 4;
  localparam int unsigned PB = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [XB-1:0] wr_x = '0;
  logic [YB-1:0] wr_y = '0;
  logic [PB-1:0] wr_rgb = '0;
  logic          rd_req = 1'b0;
  logic [XB-1:0] rd_x = '0;
  logic [YB-1:0] rd_y = '0;
  logic          scan_start = 1'b0;
  logic          busy, rd_valid, frame_done;
  logic [PB-1:0] rd_rgb;
  logic [XB-1:0] rd_x_o;
  logic [YB-1:0] rd_y_o;

  int n_chk = 0;
  int n_bad = 0;
  pixel_t model [W*H];

  frame_buffer_rgb #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .COLOR_BITS (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_rgb     (wr_rgb),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .scan_start (scan_start),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_rgb     (rd_rgb),
    .rd_x_o     (rd_x_o),
    .rd_y_o     (rd_y_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input int x, input int y, input logic [PB-1:0] v);
    wr_en  = 1'b1;
    wr_x   = XB'(x);
    wr_y   = YB'(y);
    wr_rgb = v;
    tick();
    wr_en  = 1'b0;
    if (x < int'(W) && y < int'(H)) model[y*int'(W)+x] = v;
  endtask

  // Returned word packed as {valid, x, y, rgb}.
  task automatic rd_px(input string tag, input int x, input int y, input logic [PB-1:0] v);
    rd_req = 1'b1;
    rd_x   = XB'(x);
    rd_y   = YB'(y);
    tick();
    rd_req = 1'b0;
    check_eq(tag, 64'({rd_valid, rd_x_o, rd_y_o, rd_rgb}), 64'({1'b1, XB'(x), YB'(y), v}));
  endtask

  task automatic run_scan(input int n_pix);
    logic [63:0] exp;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check_eq("scan_accept", 64'({busy, rd_valid, frame_done}), 64'(3'b100));
    for (int i = 0; i < n_pix; i++) begin
      tick();
      exp = 64'({1'b1, (i == int'(W*H) - 1), XB'(i % int'(W)), YB'(i / int'(W)),
                 PB'(model[i]), 1'b1});
      check_eq($sformatf("scan_pix%0d", i),
               64'({rd_valid, frame_done, rd_x_o, rd_y_o, rd_rgb, busy}), exp);
      if (i == 9) rd_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(W*H); i++) model[i] = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_out", 64'({busy, rd_valid, frame_done, rd_x_o, rd_y_o, rd_rgb}), 64'(0));

    // Basic write then random read
    wr_px(5, 7, 24'h112233);
    rd_px("rd_5_7", 5, 7, 24'h112233);
    check_eq("rd_idle_busy", 64'(busy), 64'(0));

    // Fill frame with its own linear index
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        wr_px(x, y, PB'(y * int'(W) + x));

    // scan_start and rd_req together: scan wins, rd_req held during scan ignored
    rd_req = 1'b1;
    rd_x   = XB'(1);
    rd_y   = YB'(1);
    run_scan(int'(W*H));
    tick();
    check_eq("scan_end", 64'({busy, rd_valid, frame_done}), 64'(0));

    // Out-of-range writes are dropped; (25,10) would alias (5,11) if unchecked
    wr_px(25, 10, 24'hFFFFFF);
    wr_px(3, 12, 24'hFFFFFF);
    rd_px("rd_alias", 5, 11, 24'd225);
    rd_px("rd_oor_x", 25, 10, 24'h0);
    rd_px("rd_oor_y", 3, 12, 24'h0);
    rd_px("rd_corner", 19, 11, 24'd239);
    rd_px("rd_origin", 0, 0, 24'd0);

    // Same-cycle read/write of one address
    wr_px(3, 3, 24'h000001);
    wr_en  = 1'b1;
    wr_x   = XB'(3);
    wr_y   = YB'(3);
    wr_rgb = 24'hABCDEF;
`ifdef FRAME_BUFFER_BYPASS_EN
    rd_px("rw_same", 3, 3, 24'hABCDEF);
`else
    rd_px("rw_same", 3, 3, 24'h000001);
`endif
    wr_en = 1'b0;
    model[3*int'(W)+3] = 24'hABCDEF;
    rd_px("rw_after", 3, 3, 24'hABCDEF);

    // Reset mid-scan, then a clean rescan from (0,0) over unchanged memory
    run_scan(100);
    rst = 1'b1;
    tick();
    check_eq("mid_rst", 64'({busy, rd_valid, frame_done, rd_x_o, rd_y_o, rd_rgb}), 64'(0));
    rst = 1'b0;
    tick();
    check_eq("post_rst", 64'({busy, rd_valid, frame_done}), 64'(0));
    run_scan(int'(W*H));
    tick();
    check_eq("rescan_end", 64'({busy, rd_valid, frame_done}), 64'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
